// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: deserialises LSB-first data bits from sampler strobes,
// checks optional parity and one/two stop bits, and keeps saturating error counters.
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  frame_start_i,
    input  logic                  bit_valid_i,
    input  logic                  sampled_bit_i,
    input  logic                  par_en_i,
    input  logic                  par_type_i,
    input  logic                  stop2_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  data_valid_o,
    output logic                  parity_err_o,
    output logic                  stop_err_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  par_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt_o
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bitCnt_q, bitCnt_d;
    logic                  runPar_q, runPar_d;
    logic                  parFail_q, parFail_d;
    logic                  stopFail_q, stopFail_d;
    logic                  cfgParEn_q, cfgParEn_d;
    logic                  cfgParType_q, cfgParType_d;
    logic                  cfgStop2_q, cfgStop2_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  dataValid_q, dataValid_d;
    logic                  parErr_q, parErr_d;
    logic                  stopErr_q, stopErr_d;
    logic [CNT_WIDTH-1:0]  parCnt_q, parCnt_d;
    logic [CNT_WIDTH-1:0]  stopCnt_q, stopCnt_d;
    logic                  complete;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            runPar_q     <= 1'b0;
            parFail_q    <= 1'b0;
            stopFail_q   <= 1'b0;
            cfgParEn_q   <= 1'b0;
            cfgParType_q <= 1'b0;
            cfgStop2_q   <= 1'b0;
            dataOut_q    <= '0;
            dataValid_q  <= 1'b0;
            parErr_q     <= 1'b0;
            stopErr_q    <= 1'b0;
            parCnt_q     <= '0;
            stopCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            runPar_q     <= runPar_d;
            parFail_q    <= parFail_d;
            stopFail_q   <= stopFail_d;
            cfgParEn_q   <= cfgParEn_d;
            cfgParType_q <= cfgParType_d;
            cfgStop2_q   <= cfgStop2_d;
            dataOut_q    <= dataOut_d;
            dataValid_q  <= dataValid_d;
            parErr_q     <= parErr_d;
            stopErr_q    <= stopErr_d;
            parCnt_q     <= parCnt_d;
            stopCnt_q    <= stopCnt_d;
        end
    end

    // frame_start has priority everywhere: it aborts any frame silently and drops a coincident strobe
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        runPar_d     = runPar_q;
        parFail_d    = parFail_q;
        stopFail_d   = stopFail_q;
        cfgParEn_d   = cfgParEn_q;
        cfgParType_d = cfgParType_q;
        cfgStop2_d   = cfgStop2_q;
        dataOut_d    = dataOut_q;
        dataValid_d  = 1'b0;
        parErr_d     = 1'b0;
        stopErr_d    = 1'b0;
        complete     = 1'b0;

        if (frame_start_i) begin
            state_d      = DATA;
            shift_d      = '0;
            bitCnt_d     = '0;
            runPar_d     = 1'b0;
            parFail_d    = 1'b0;
            stopFail_d   = 1'b0;
            cfgParEn_d   = par_en_i;
            cfgParType_d = par_type_i;
            cfgStop2_d   = stop2_i;
        end else if (bit_valid_i) begin
            case (state_q)
                IDLE: ;
                DATA: begin
                    shift_d  = {sampled_bit_i, shift_q[DATA_WIDTH-1:1]};
                    runPar_d = runPar_q ^ sampled_bit_i;
                    if (bitCnt_q == LAST_BIT) begin
                        bitCnt_d = '0;
                        state_d  = cfgParEn_q ? PARITY : STOP1;
                    end else begin
                        bitCnt_d = bitCnt_q + BCW'(1);
                    end
                end
                PARITY: begin
                    parFail_d = runPar_q ^ sampled_bit_i ^ cfgParType_q;
                    state_d   = STOP1;
                end
                STOP1: begin
                    stopFail_d = ~sampled_bit_i;
                    if (cfgStop2_q) begin
                        state_d = STOP2;
                    end else begin
                        complete = 1'b1;
                    end
                end
                STOP2: begin
                    stopFail_d = stopFail_q | ~sampled_bit_i;
                    complete   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (complete) begin
            state_d     = IDLE;
            dataOut_d   = shift_q;
            parErr_d    = parFail_q;
            stopErr_d   = stopFail_d;
            dataValid_d = ~(parFail_q | stopFail_d);
        end
    end

    // Counters move on the same edge that raises their pulse; clear beats increment
    always_comb begin
        parCnt_d  = parCnt_q;
        stopCnt_d = stopCnt_q;
        if (err_clr_i) begin
            parCnt_d  = '0;
            stopCnt_d = '0;
        end else begin
            if (parErr_d && (parCnt_q != '1)) begin
                parCnt_d = parCnt_q + CNT_WIDTH'(1);
            end
            if (stopErr_d && (stopCnt_q != '1)) begin
                stopCnt_d = stopCnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign data_out_o     = dataOut_q;
    assign data_valid_o   = dataValid_q;
    assign parity_err_o   = parErr_q;
    assign stop_err_o     = stopErr_q;
    assign busy_o         = (state_q != IDLE);
    assign par_err_cnt_o  = parCnt_q;
    assign stop_err_cnt_o = stopCnt_q;

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Parametrised UART RX frame checker that replaces the single-bit stop check in the UART RX path.
- Consumes the sampler's per-bit strobes after start-bit validation and deserialises DATA_WIDTH data bits, LSB first.
- Checks optional parity and one or two stop bits, then emits the data word with per-frame error pulses.
- Keeps saturating parity-error and stop-error counters for the register file.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk  input  1  system clock (UART RX clock domain).
- rst  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse from the RX controller after the start bit is validated.
- bit_valid  input  1  one-cycle strobe; sampled_bit is valid in that cycle.
- sampled_bit  input  1  majority-sampled line value.
- par_en  input  1  1 = a parity bit follows the data bits.
- par_type  input  1  0 = even parity, 1 = odd parity.
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- err_clr  input  1  synchronous clear of both error counters.
- data_out  output  DATA_WIDTH  received word; held until the next completed frame.
- data_valid  output  1  one-cycle pulse; frame complete with no error.
- parity_err  output  1  one-cycle pulse; parity mismatch in the completed frame.
- stop_err  output  1  one-cycle pulse; any stop bit sampled as 0.
- busy  output  1  high while the FSM is not in IDLE.
- par_err_cnt  output  CNT_WIDTH  saturating count of parity_err pulses.
- stop_err_cnt  output  CNT_WIDTH  saturating count of stop_err pulses.

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE. All outputs, the shift register, the bit counter and the latched config are 0.
- Config latch: par_en, par_type and stop2 are latched on frame_start. Changing these inputs mid-frame has no effect on the frame in progress.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2, all clocked on clk.
- IDLE: bit_valid is ignored. frame_start moves to DATA and clears the bit counter and the running parity.
- DATA: on each bit_valid, shift sampled_bit in at the MSB end (LSB-first reception) and XOR it into the running parity. After the DATA_WIDTH-th bit, go to PARITY if par_en is set, otherwise to STOP1.
- PARITY: on bit_valid, set par_fail = running_parity ^ sampled_bit ^ par_type, then go to STOP1.
- STOP1: on bit_valid, set stop_fail = ~sampled_bit. Go to STOP2 if stop2 is set; otherwise complete the frame.
- STOP2: on bit_valid, OR ~sampled_bit into stop_fail, then complete the frame.
- Frame completion, on the clock edge after the final strobe is sampled (latency 1 cycle):
  - data_out loads the shift register.
  - parity_err = par_fail, stop_err = stop_fail.
  - data_valid = ~(par_fail | stop_fail).
  - FSM returns to IDLE. All pulses last exactly one cycle.
- data_out is updated on every completed frame, including errored ones.
- frame_start while busy: the current frame is aborted with no pulses and no counter change. A new frame starts with the config latched in that cycle.
- frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.
- A state only advances on bit_valid. There is no timeout; cycles without strobes hold state.
- Counters:
  - Each counter increments by 1 on its error pulse and saturates at 2^CNT_WIDTH-1.
  - A frame with both errors increments both counters.
  - err_clr sets both counters to 0. If err_clr coincides with an increment, clear wins and the result is 0.

Test Plan:
- DATA_WIDTH=8, par_en=0, stop2=0, bits of 0xA5 LSB-first, stop=1 -> one cycle after the stop strobe: data_out=0xA5, data_valid=1, both err=0, busy falls.
- par_en=1, par_type=0, data 0x07, parity bit 0 -> parity_err=1, data_valid=0, par_err_cnt 0->1. Repeat with parity bit 1 -> data_valid=1, count unchanged.
- stop2=1, data 0x3C, stop bits 1 then 0 -> stop_err=1, stop_err_cnt +1, data_out=0x3C. Stop bits 1,1 -> data_valid=1.
- frame_start after 4 data bits, then a full frame of 0x5A -> no pulse for the aborted frame, data_out=0x5A; a bit_valid coincident with that frame_start is ignored.
- CNT_WIDTH=2, five stop-error frames -> stop_err_cnt reads 1,2,3,3,3. err_clr coincident with a sixth error -> 0.
- Reset asserted mid-DATA -> all outputs 0 immediately. After release, bit_valid without frame_start produces no output.
